// File: rtl/rom_loader.sv
// ROM download controller: captures ioctl bytes into a small FIFO and writes them
// to SDRAM port1 (linear CPU ROM) and port2 (remapped graphics ROM) via toggle handshakes.
module rom_loader #(
  parameter logic [24:0] GFX_BASE   = 25'h00C000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_downl,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic        reset_req,
  output logic        port1_req,
  input  logic        port1_ack,
  output logic [22:0] port1_a,
  output logic [1:0]  port1_ds,
  output logic        port1_we,
  output logic [15:0] port1_d,
  output logic        port2_req,
  input  logic        port2_ack,
  output logic [22:0] port2_a,
  output logic [1:0]  port2_ds,
  output logic        port2_we,
  output logic [15:0] port2_d,
  output logic        busy,
  output logic        overflow,
  output logic        rom_loaded,
  output logic        core_reset
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  typedef enum logic {IDLE, WAIT} state_t;
  state_t state;

  logic          wr_last;
  logic          dl_last;
  logic          dl_seen;
  logic [32:0]   mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic          push;
  logic          pop;
  logic          accept;
  logic          full;
  logic          empty;
  logic          load_done;
  logic [32:0]   head;
  logic [24:0]   head_addr;
  logic [7:0]    head_data;
  logic [24:0]   gfx_off;
  logic          is_gfx;
  logic          unused_gfx_msb;

  assign push      = ioctl_downl & ioctl_wr & ~wr_last & (ioctl_index == 8'd0);
  assign empty     = (count == '0);
  assign full      = (count == CW'(FIFO_DEPTH));
  assign pop       = (state == IDLE) & ~empty;
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign accept    = push & (~full | pop);
  assign head      = mem[rd_ptr];
  assign head_addr = head[32:8];
  assign head_data = head[7:0];
  assign gfx_off   = head_addr - GFX_BASE;
  assign is_gfx    = (head_addr >= GFX_BASE);
  assign busy      = ~empty | (state == WAIT);
  assign load_done = ~ioctl_downl & dl_seen & empty & (state == IDLE);
  assign unused_gfx_msb = gfx_off[24];

  always_ff @(posedge clk_sys) begin
    if (accept) mem[wr_ptr] <= {ioctl_addr, ioctl_dout};
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(accept) - CW'(pop);
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_last    <= 1'b0;
      dl_last    <= 1'b0;
      dl_seen    <= 1'b0;
      overflow   <= 1'b0;
      rom_loaded <= 1'b0;
      core_reset <= 1'b1;
    end else begin
      wr_last    <= ioctl_wr;
      dl_last    <= ioctl_downl;
      core_reset <= reset_req | ~rom_loaded | ioctl_downl;
      if (push & ~accept)
        overflow <= 1'b1;
      else if (ioctl_downl & ~dl_last)
        overflow <= 1'b0;
      if (ioctl_downl)
        dl_seen <= 1'b1;
      else if (load_done) begin
        dl_seen    <= 1'b0;
        rom_loaded <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state     <= IDLE;
      port1_req <= 1'b0;
      port1_a   <= '0;
      port1_ds  <= '0;
      port1_we  <= 1'b0;
      port1_d   <= '0;
      port2_req <= 1'b0;
      port2_a   <= '0;
      port2_ds  <= '0;
      port2_we  <= 1'b0;
      port2_d   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            port1_a   <= head_addr[23:1];
            port1_ds  <= {head_addr[0], ~head_addr[0]};
            port1_d   <= {2{head_data}};
            port1_we  <= 1'b1;
            port1_req <= ~port1_req;
            if (is_gfx) begin
              // Graphics bytes are interleaved: offset bit 14 picks the byte lane.
              port2_a   <= {gfx_off[23:15], gfx_off[13:0]};
              port2_ds  <= {~gfx_off[14], gfx_off[14]};
              port2_d   <= {2{head_data}};
              port2_we  <= 1'b1;
              port2_req <= ~port2_req;
            end
            state <= WAIT;
          end
        end
        WAIT: begin
          if ((port1_ack == port1_req) && (port2_ack == port2_req)) begin
            port1_we <= 1'b0;
            port2_we <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
